alu_iter_exec: RTL and testbench
================================

# alu_iter_exec

Sequential execute unit: consumes the 4-bit `Operation` code produced by the ALU controller together with two operands, and returns a registered result over a valid/ready handshake. Logic ops, add/sub and compares complete in one cycle. Shifts run iteratively, one bit position per cycle, so the pipeline stalls on `in_ready` instead of carrying a barrel shifter. It sits in the EX stage between the ID/EX register and the EX/MEM register.

## Interface
- `DATA_WIDTH`, 32, operand/result width; must be a power of two ≥ 8
- `SHAMT_W`, $clog2(DATA_WIDTH), shift-amount width (derived, not overridden)

- `clk`  input  1  rising-edge clock
- `rst_n`  input  1  asynchronous, active-low reset
- `in_valid`  input  1  operation, SrcA and SrcB are valid
- `in_ready`  output  1  unit accepts an operation this cycle
- `Operation`  input  4  operation code
- `SrcA`  input  DATA_WIDTH  operand A
- `SrcB`  input  DATA_WIDTH  operand B; for shifts, `SrcB[SHAMT_W-1:0]` is the shift amount
- `flush`  input  1  synchronous kill of the in-flight operation
- `out_valid`  output  1  `ALUResult` and `Zero` are valid
- `out_ready`  input  1  downstream consumes the result
- `ALUResult`  output  DATA_WIDTH  registered result
- `Zero`  output  1  registered, `ALUResult == 0`
- `busy`  output  1  state is not IDLE

## Operation
- Operation codes:
  - 0000 AND
  - 0001 OR
  - 0100 ADD
  - 0101 SUB, computed as A − B modulo 2^DATA_WIDTH
  - 1000 EQ, result = {0…, A==B}
  - 1100 SLT, signed compare, result = {0…, $signed(A) < $signed(B)}
  - 0110 SLL
  - 0111 SRL
  - 0011 SRA
  - Any other code yields result 0 with one-cycle latency.
- An operation is accepted when `in_valid && in_ready`.
- State IDLE:
  - On accept of a non-shift op, register the result and go to DONE.
  - On accept of a shift op with shamt = 0, register SrcA unchanged and go to DONE.
  - On accept of a shift op with shamt > 0, load the working register with SrcA and the counter with shamt, then go to SHIFT.
- State SHIFT:
  - Each cycle, shift the working register by 1 in the requested direction. SRA replicates the MSB; SLL and SRL insert 0.
  - Decrement the counter each cycle. When the counter reaches 1, the step completes and the next state is DONE.
- State DONE:
  - `out_valid` = 1.
  - `ALUResult` and `Zero` are held stable until `out_ready`.
  - On `out_ready` with no new accept, go to IDLE.
  - On `out_ready` with a simultaneous accept, behave as IDLE-accept, giving back-to-back operation.
- `in_ready` is combinational: (state == IDLE) || (state == DONE && out_ready). It is 0 in SHIFT.
- `flush` has the highest priority:
  - The next state is IDLE and `out_valid` falls next cycle.
  - An `in_valid` in the same cycle is discarded even if `in_ready` is 1.
  - A flush in IDLE has no effect.
- Operands are sampled only at accept. Input changes during SHIFT or DONE are ignored.

## Timing
- Reset (async assert, sync-safe deassert), forced to: state IDLE, `out_valid` 0, `ALUResult` 0, `Zero` 0, `busy` 0, counter 0.
- `in_ready` reads 1 while held in reset, because the state is IDLE.
- Non-shift latency: accept at edge N gives `out_valid` = 1 after edge N+1, i.e. visible during cycle N+1.
- Shift latency: 1 + shamt cycles from accept to `out_valid`. The maximum is DATA_WIDTH cycles (shamt = DATA_WIDTH−1).
- Throughput: one non-shift op per cycle when `out_ready` is held 1.
- Zero is computed from the final result in the same edge that result is registered; it is never a stale value from an earlier op.
- Reset asserted mid-SHIFT or mid-DONE: outputs return to reset values immediately, asynchronously. No partial result is ever presented.

## Structure
- Package `alu_pkg`, containing:
  - `localparam` constants for every Operation code listed above, shared with the ALU controller;
  - `typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t`;
  - a function `is_shift(op)`.
- Sub-module `alu_shift_step`: combinational single-bit shifter. Inputs: value, dir (left/right), arith. Output: shifted value. Instantiated once in the SHIFT datapath.
- The rest is a single always_ff block (state, counter, working and result registers) plus a single always_comb block (next state, one-cycle result mux).

## Test plan
- ADD A=0x0000_0005, B=0x0000_0003, `out_ready`=1 → one cycle later `out_valid`=1, ALUResult=0x8, Zero=0. Follow with SUB 7−7 → ALUResult=0, Zero=1 on the next cycle (back-to-back).
- SRA A=0x8000_0000, shamt=4 → `in_ready`=0 for 4 cycles, `out_valid` on cycle 5, ALUResult=0xF800_0000. SRL of the same operands → 0x0800_0000. SLL A=1, shamt=31 → 0x8000_0000 after 32 cycles.
- Shift with shamt=0, A=0x1234_5678 → result 0x1234_5678 after 1 cycle. SLT A=0xFFFF_FFFF, B=1 → 1. EQ A=B=0xDEAD_BEEF → 1. Undefined code 1111 → 0, Zero=1.
- Hold `out_ready`=0 for 3 cycles after a result → ALUResult/Zero stable, `in_ready`=0. Release together with a pending `in_valid` → old result consumed, new op accepted on the same edge.
- `flush` on cycle 2 of a 10-step SLL with `in_valid`=1 in the same cycle → IDLE next cycle, `out_valid` never asserts, the concurrent op is not accepted.
- Assert `rst_n`=0 mid-SHIFT (asynchronously, between edges) → `out_valid`, ALUResult, Zero and `busy` go to 0 immediately. After release, a new ADD completes normally.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the iterative execute unit: operation codes used by
// both the ALU controller and the execute unit, FSM state type and op helpers.
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_AND = 4'b0000;
  localparam logic [OP_W-1:0] OP_OR  = 4'b0001;
  localparam logic [OP_W-1:0] OP_ADD = 4'b0100;
  localparam logic [OP_W-1:0] OP_SUB = 4'b0101;
  localparam logic [OP_W-1:0] OP_EQ  = 4'b1000;
  localparam logic [OP_W-1:0] OP_SLT = 4'b1100;
  localparam logic [OP_W-1:0] OP_SLL = 4'b0110;
  localparam logic [OP_W-1:0] OP_SRL = 4'b0111;
  localparam logic [OP_W-1:0] OP_SRA = 4'b0011;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} alu_state_t;

  // True for the three shift codes, which run iteratively.
  function automatic logic is_shift(input logic [OP_W-1:0] op);
    return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
  endfunction

endpackage

// File: rtl/alu_shift_step.sv
// Combinational single-position shifter used once per SHIFT cycle.
// dir = 1 shifts left, dir = 0 shifts right; arith replicates the MSB on
// right shifts and is ignored on left shifts.
module alu_shift_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] value,
  input  logic                  dir,
  input  logic                  arith,
  output logic [DATA_WIDTH-1:0] shifted
);

  logic fill;

  // Select the bit shifted in and produce the one-position result.
  always_comb begin
    fill    = arith & value[DATA_WIDTH-1];
    shifted = value;
    if (dir) shifted = {value[DATA_WIDTH-2:0], 1'b0};
    else     shifted = {fill, value[DATA_WIDTH-1:1]};
  end

endmodule

// File: rtl/alu_iter_exec.sv
// EX-stage execute unit. Logic, arithmetic and compare ops finish in one
// cycle; shifts walk one bit position per cycle, stalling in_ready meanwhile.
// The result is held in DONE until downstream takes it.
module alu_iter_exec
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            Operation,
  input  logic [DATA_WIDTH-1:0] SrcA,
  input  logic [DATA_WIDTH-1:0] SrcB,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] ALUResult,
  output logic                  Zero,
  output logic                  busy
);

  localparam int SHAMT_W = $clog2(DATA_WIDTH);

  alu_state_t                  state_q, state_nx;
  logic [SHAMT_W-1:0]          cnt_q;
  logic [DATA_WIDTH-1:0]       work_q;
  logic                        dir_left_q;
  logic                        arith_q;
  logic [DATA_WIDTH-1:0]       res_q;
  logic                        zero_q;

  logic                        accept;
  logic                        start_shift;
  logic [SHAMT_W-1:0]          shamt;
  logic [DATA_WIDTH-1:0]       res_nx;
  logic [DATA_WIDTH-1:0]       step_out;
  logic signed [DATA_WIDTH-1:0] a_s, b_s;

  alu_shift_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .value   (work_q),
    .dir     (dir_left_q),
    .arith   (arith_q),
    .shifted (step_out)
  );

  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign ALUResult = res_q;
  assign Zero      = zero_q;

  // Handshake, next-state selection and the single-cycle result mux.
  always_comb begin
    in_ready    = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    accept      = in_valid && in_ready && !flush;
    shamt       = SrcB[SHAMT_W-1:0];
    start_shift = is_shift(Operation) && (shamt != '0);
    a_s         = SrcA;
    b_s         = SrcB;
    res_nx      = '0;
    state_nx    = state_q;

    case (Operation)
      OP_AND:  res_nx = SrcA & SrcB;
      OP_OR:   res_nx = SrcA | SrcB;
      OP_ADD:  res_nx = SrcA + SrcB;
      OP_SUB:  res_nx = SrcA - SrcB;
      OP_EQ:   res_nx = {{(DATA_WIDTH-1){1'b0}}, (SrcA == SrcB)};
      OP_SLT:  res_nx = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
      // A shift by zero passes SrcA through; nonzero shifts ignore this value.
      OP_SLL, OP_SRL, OP_SRA: res_nx = SrcA;
      default: res_nx = '0;
    endcase

    case (state_q)
      IDLE: begin
        if (accept) state_nx = start_shift ? SHIFT : DONE;
      end
      SHIFT: begin
        if (cnt_q == SHAMT_W'(1)) state_nx = DONE;
      end
      DONE: begin
        if (accept)         state_nx = start_shift ? SHIFT : DONE;
        else if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    // Flush wins over everything, including a same-cycle accept.
    if (flush) state_nx = IDLE;
  end

  // State, shift counter, working register and registered result/Zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      dir_left_q <= 1'b0;
      arith_q    <= 1'b0;
      res_q      <= '0;
      zero_q     <= 1'b0;
    end else begin
      state_q <= state_nx;
      if (accept) begin
        if (start_shift) begin
          work_q     <= SrcA;
          cnt_q      <= shamt;
          dir_left_q <= (Operation == OP_SLL);
          arith_q    <= (Operation == OP_SRA);
        end else begin
          res_q  <= res_nx;
          zero_q <= (res_nx == '0);
        end
      end else if (flush) begin
        cnt_q <= '0;
      end else if (state_q == SHIFT) begin
        work_q <= step_out;
        cnt_q  <= cnt_q - SHAMT_W'(1);
        // Last step: Zero is derived from the very value being registered.
        if (cnt_q == SHAMT_W'(1)) begin
          res_q  <= step_out;
          zero_q <= (step_out == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_iter_exec.sv
// Scoreboard bench for alu_iter_exec: stimulus pushes expected {Zero, result}
// at accept, a monitor pops and compares on every completed output handshake.
module tb_alu_iter_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  Operation;
  logic [31:0] SrcA, SrcB;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [32:0] exp_q[$];

  alu_iter_exec #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .Operation (Operation),
    .SrcA      (SrcA),
    .SrcB      (SrcB),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUResult (ALUResult),
    .Zero      (Zero),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: {zero, result} from the operation's arithmetic definition.
  function automatic logic [32:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic signed [31:0] sa, sb;
    int sh;
    sa = a; sb = b; sh = int'(b[4:0]);
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0100: r = a + b;
      4'b0101: r = a - b;
      4'b1000: r = (a == b) ? 32'd1 : 32'd0;
      4'b1100: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b0110: r = a << sh;
      4'b0111: r = a >> sh;
      4'b0011: r = sa >>> sh;
      default: r = 32'd0;
    endcase
    return {(r == 32'd0), r};
  endfunction

  // Monitor: every output handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {31'd0, Zero, ALUResult}, 64'h1_FFFF_FFFF_FFFF);
      end else begin
        logic [32:0] e;
        e = exp_q.pop_front();
        check("result", {31'd0, Zero, ALUResult}, {31'd0, e});
      end
    end
  end

  // Present one op and hold it until accepted; returns at posedge+1 after accept.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit use_exp, input logic [32:0] exp, input bit rnd_rdy);
    int  waited = 0;
    bit  done = 0;
    Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready && !flush) begin
        exp_q.push_back(use_exp ? exp : model(op, a, b));
        done = 1;
      end else if (waited > 100) begin
        check("accept_timeout", 64'd0, 64'd1);
        done = 1;
      end
      waited++;
      @(posedge clk); #1;
      if (!done && rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end
    in_valid = 1'b0;
    // Junk on the operand bus after accept must not disturb the op in flight.
    Operation = 4'($urandom); SrcA = $urandom; SrcB = $urandom;
  endtask

  // Count cycles without out_valid after an accept.
  task automatic wait_out(output int n);
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 64) begin
      n++;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int k = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain_empty", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int lat;
    int seen;
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    Operation = 4'd0; SrcA = 32'd0; SrcB = 32'd0;
    #3;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_result", {31'd0, Zero, ALUResult}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;

    // ADD then SUB back-to-back
    issue(4'b0100, 32'h5, 32'h3, 1, {1'b0, 32'h8}, 0);
    @(negedge clk);
    check("add_latency_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    issue(4'b0100, 32'h5, 32'h3, 1, {1'b0, 32'h8}, 0);
    issue(4'b0101, 32'h7, 32'h7, 1, {1'b1, 32'h0}, 0);
    @(negedge clk);
    check("b2b_valid", {63'd0, out_valid}, 64'd1);
    @(posedge clk); #1;
    drain();

    // Shift timing and values
    issue(4'b0011, 32'h8000_0000, 32'd4, 1, {1'b0, 32'hF800_0000}, 0);
    wait_out(lat);
    check("sra4_latency", 64'(lat), 64'd4);
    issue(4'b0111, 32'h8000_0000, 32'd4, 1, {1'b0, 32'h0800_0000}, 0);
    wait_out(lat);
    check("srl4_latency", 64'(lat), 64'd4);
    issue(4'b0110, 32'h1, 32'd31, 1, {1'b0, 32'h8000_0000}, 0);
    wait_out(lat);
    check("sll31_latency", 64'(lat), 64'd31);
    issue(4'b0111, 32'h1234_5678, 32'd0, 1, {1'b0, 32'h1234_5678}, 0);
    wait_out(lat);
    check("shamt0_latency", 64'(lat), 64'd0);
    issue(4'b1100, 32'hFFFF_FFFF, 32'd1, 1, {1'b0, 32'h1}, 0);
    issue(4'b1000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1, {1'b0, 32'h1}, 0);
    issue(4'b1111, 32'h1234_5678, 32'h1, 1, {1'b1, 32'h0}, 0);
    drain();

    // Back-pressure hold, then release with a pending op
    out_ready = 1'b0;
    issue(4'b0100, 32'h10, 32'h20, 1, {1'b0, 32'h30}, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, out_valid}, 64'd1);
      check("hold_result", {31'd0, Zero, ALUResult}, {31'd0, 1'b0, 32'h30});
      check("hold_in_ready", {63'd0, in_ready}, 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    issue(4'b0001, 32'hF0, 32'h0F, 1, {1'b0, 32'hFF}, 0);
    drain();

    // Flush mid-SHIFT with a concurrent in_valid
    issue(4'b0110, 32'h3, 32'd10, 0, 33'd0, 0);
    @(posedge clk); #1;
    flush = 1'b1; in_valid = 1'b1; Operation = 4'b0100; SrcA = 32'h1; SrcB = 32'h1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    void'(exp_q.pop_back());
    check("flush_busy", {63'd0, busy}, 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    @(posedge clk); #1;

    // Flush in IDLE with in_valid: op must be discarded
    flush = 1'b1; in_valid = 1'b1; Operation = 4'b0100;
    #1;
    check("idle_flush_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("idle_flush_busy", {63'd0, busy}, 64'd0);
    check("idle_flush_valid", {63'd0, out_valid}, 64'd0);

    // Async reset mid-SHIFT after a nonzero result has been registered
    issue(4'b0001, 32'hA5, 32'h5A, 0, 33'd0, 0);
    issue(4'b0011, 32'h9000_0000, 32'd20, 0, 33'd0, 0);
    repeat (3) @(posedge clk);
    #2; rst_n = 1'b0;
    #1;
    check("areset_valid", {63'd0, out_valid}, 64'd0);
    check("areset_busy", {63'd0, busy}, 64'd0);
    check("areset_result", {31'd0, Zero, ALUResult}, 64'd0);
    check("areset_in_ready", {63'd0, in_ready}, 64'd1);
    exp_q.delete();
    @(posedge clk); @(posedge clk); #2; rst_n = 1'b1;
    @(posedge clk); #1;
    issue(4'b0100, 32'h1, 32'h2, 1, {1'b0, 32'h3}, 0);
    drain();

    // Randomized ops with random back-pressure
    for (int i = 0; i < 200; i++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom);
      a  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      b  = ($urandom_range(0, 7) == 0) ? a : $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      issue(op, a, b, 0, 33'd0, 1);
      repeat ($urandom_range(0, 1)) begin
        out_ready = ($urandom_range(0, 3) != 0);
        @(posedge clk); #1;
      end
    end
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
